// File: rtl/hazard_ctrl.sv
// Hazard and control-recovery unit: load-use / HI-LO stalls, EXE-stage branch
// resolution with flush+redirect, mult/div interlock FSM, predictor update, perf counters.
module hazard_ctrl #(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rsa,
   input  logic [4:0]  id_rta,
   input  logic        id_use_rs,
   input  logic        id_use_rt,
   input  logic        id_hilo_use,
   input  logic [4:0]  exe_rwa,
   input  logic        exe_drce,
   input  logic [31:0] exe_pc,
   input  logic [31:0] exe_npc,
   input  logic        exe_pred_branch,
   input  logic        exe_pred_taken,
   input  logic [31:0] exe_pred_npc,
   input  logic        exe_branch,
   input  logic        exe_taken,
   input  logic [31:0] exe_target,
   input  logic        exe_md_start,
   output logic        pc_stall,
   output logic        ifid_stall,
   output logic        idexe_stall,
   output logic        ifid_flush,
   output logic        idexe_flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        md_busy,
   output logic        md_done,
   output logic        bp_upd_valid,
   output logic [31:0] bp_upd_pc,
   output logic [31:0] bp_upd_target,
   output logic        bp_upd_taken,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [5:0] CNT_INIT = 6'(MD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        lu, mis, hl, stall;
   logic        bp_valid_q, bp_valid_d, bp_taken_q, bp_taken_d;
   logic [31:0] bp_pc_q, bp_pc_d, bp_target_q, bp_target_d;
   logic [31:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

   // Hazard detection and branch resolution are purely combinational.
   always_comb begin
      lu  = exe_drce && (exe_rwa != 5'd0) &&
            ((id_use_rs && (id_rsa == exe_rwa)) || (id_use_rt && (id_rta == exe_rwa)));
      mis = (exe_branch && ((exe_taken != exe_pred_taken) ||
                            (exe_taken && (exe_target != exe_pred_npc)))) ||
            (!exe_branch && exe_pred_branch && exe_pred_taken);
      hl  = md_busy && id_hilo_use;
      // The ID instruction is wrong-path on a mispredict, so never hold it.
      stall = !mis && (lu || hl);
   end

   assign pc_stall       = stall;
   assign ifid_stall     = stall;
   assign idexe_stall    = stall;
   assign ifid_flush     = mis;
   assign idexe_flush    = mis;
   assign redirect_valid = mis;
   assign redirect_pc    = (exe_branch && exe_taken) ? exe_target : exe_npc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            if (exe_md_start) begin
               state_d = BUSY;
               cnt_d   = CNT_INIT;
            end
         end
         BUSY: begin
            if (exe_md_start) begin
               cnt_d = CNT_INIT;
            end else if (cnt_q != 6'd0) begin
               cnt_d = cnt_q - 6'd1;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      md_busy = (state_q == BUSY);
      md_done = (state_q == BUSY) && (cnt_q == 6'd0);
   end

   always_comb begin
      bp_valid_d    = exe_branch;
      bp_pc_d       = exe_branch ? exe_pc     : bp_pc_q;
      bp_taken_d    = exe_branch ? exe_taken  : bp_taken_q;
      bp_target_d   = exe_branch ? exe_target : bp_target_q;
      branch_cnt_d  = branch_cnt_q + {31'd0, exe_branch};
      mispred_cnt_d = mispred_cnt_q + {31'd0, mis};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bp_valid_q    <= 1'b0;
         bp_pc_q       <= 32'd0;
         bp_taken_q    <= 1'b0;
         bp_target_q   <= 32'd0;
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         bp_valid_q    <= bp_valid_d;
         bp_pc_q       <= bp_pc_d;
         bp_taken_q    <= bp_taken_d;
         bp_target_q   <= bp_target_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bp_upd_valid  = bp_valid_q;
   assign bp_upd_pc     = bp_pc_q;
   assign bp_upd_taken  = bp_taken_q;
   assign bp_upd_target = bp_target_q;
   assign branch_cnt    = branch_cnt_q;
   assign mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table with scoreboard queues, then hand-written
// mult/div, reset-mid-busy and counter-wrap sequences.
module tb_hazard_ctrl;
   localparam int MDC = 4;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [4:0]  id_rsa, id_rta, exe_rwa;
   logic        id_use_rs, id_use_rt, id_hilo_use, exe_drce;
   logic [31:0] exe_pc, exe_npc, exe_pred_npc, exe_target;
   logic        exe_pred_branch, exe_pred_taken, exe_branch, exe_taken, exe_md_start;
   logic        pc_stall, ifid_stall, idexe_stall, ifid_flush, idexe_flush, redirect_valid;
   logic [31:0] redirect_pc, bp_upd_pc, bp_upd_target, branch_cnt, mispred_cnt;
   logic        md_busy, md_done, bp_upd_valid, bp_upd_taken;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MD_CYCLES(MDC)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rsa(id_rsa), .id_rta(id_rta), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_hilo_use(id_hilo_use), .exe_rwa(exe_rwa), .exe_drce(exe_drce),
      .exe_pc(exe_pc), .exe_npc(exe_npc), .exe_pred_branch(exe_pred_branch),
      .exe_pred_taken(exe_pred_taken), .exe_pred_npc(exe_pred_npc),
      .exe_branch(exe_branch), .exe_taken(exe_taken), .exe_target(exe_target),
      .exe_md_start(exe_md_start),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idexe_stall(idexe_stall),
      .ifid_flush(ifid_flush), .idexe_flush(idexe_flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .md_busy(md_busy), .md_done(md_done),
      .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc),
      .bp_upd_target(bp_upd_target), .bp_upd_taken(bp_upd_taken),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   typedef struct {
      string       name;
      logic [4:0]  rsa, rta, rwa;
      logic        use_rs, use_rt, hilo, drce;
      logic        br, tk, pbr, ptk;
      logic [31:0] pc, pnpc, tgt;
      logic        x_stall, x_mis;
      logic [31:0] x_rpc;
   } vec_t;

   typedef struct { string name; logic stall, mis; logic [31:0] rpc; } exp_t;
   typedef struct { string name; logic v, tk; logic [31:0] pc, tgt; } bpe_t;

   vec_t vt[$];
   exp_t exp_q[$];
   bpe_t bp_q[$];
   logic [31:0] m_bc, m_mc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      id_rsa = 0; id_rta = 0; exe_rwa = 0; id_use_rs = 0; id_use_rt = 0; id_hilo_use = 0;
      exe_drce = 0; exe_pc = 32'h00400000; exe_npc = 32'h00400004; exe_pred_npc = 0;
      exe_target = 0; exe_pred_branch = 0; exe_pred_taken = 0; exe_branch = 0;
      exe_taken = 0; exe_md_start = 0;
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      bpe_t b;
      id_rsa = v.rsa; id_rta = v.rta; exe_rwa = v.rwa; id_use_rs = v.use_rs;
      id_use_rt = v.use_rt; id_hilo_use = v.hilo; exe_drce = v.drce;
      exe_pc = v.pc; exe_npc = v.pc + 32'd4; exe_pred_npc = v.pnpc; exe_target = v.tgt;
      exe_pred_branch = v.pbr; exe_pred_taken = v.ptk; exe_branch = v.br; exe_taken = v.tk;
      exe_md_start = 1'b0;
      e.name = v.name; e.stall = v.x_stall; e.mis = v.x_mis; e.rpc = v.x_rpc;
      exp_q.push_back(e);
      b.name = v.name; b.v = v.br; b.tk = v.tk; b.pc = v.pc; b.tgt = v.tgt;
      bp_q.push_back(b);
   endtask

   task automatic check_cycle();
      exp_t e;
      bpe_t b;
      e = exp_q.pop_front();
      chk({e.name, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, e.stall});
      chk({e.name, ".ifid_stall"}, {31'd0, ifid_stall}, {31'd0, e.stall});
      chk({e.name, ".idexe_stall"}, {31'd0, idexe_stall}, {31'd0, e.stall});
      chk({e.name, ".flush"}, {30'd0, ifid_flush, idexe_flush}, {30'd0, e.mis, e.mis});
      chk({e.name, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.mis});
      chk({e.name, ".redirect_pc"}, redirect_pc, e.rpc);
      chk({e.name, ".branch_cnt"}, branch_cnt, m_bc);
      chk({e.name, ".mispred_cnt"}, mispred_cnt, m_mc);
      if (bp_q.size() > 1) begin
         b = bp_q.pop_front();
         chk({b.name, ".bp_upd_valid"}, {31'd0, bp_upd_valid}, {31'd0, b.v});
         if (b.v) begin
            chk({b.name, ".bp_upd_pc"}, bp_upd_pc, b.pc);
            chk({b.name, ".bp_upd_taken"}, {31'd0, bp_upd_taken}, {31'd0, b.tk});
            chk({b.name, ".bp_upd_target"}, bp_upd_target, b.tgt);
         end
      end
   endtask

   initial begin
      vec_t z, v;
      z.name = "idle"; z.rsa = 0; z.rta = 0; z.rwa = 0; z.use_rs = 0; z.use_rt = 0;
      z.hilo = 0; z.drce = 0; z.br = 0; z.tk = 0; z.pbr = 0; z.ptk = 0;
      z.pc = 32'h00400000; z.pnpc = 0; z.tgt = 0; z.x_stall = 0; z.x_mis = 0;
      z.x_rpc = 32'h00400004;

      vt.push_back(z);
      v = z; v.name = "lu_rs"; v.drce = 1; v.rwa = 5; v.use_rs = 1; v.rsa = 5; v.x_stall = 1; vt.push_back(v);
      v.name = "lu_r0"; v.rwa = 0; v.rsa = 0; v.x_stall = 0; vt.push_back(v);
      v = z; v.name = "lu_rt"; v.drce = 1; v.rwa = 7; v.use_rt = 1; v.rta = 7; v.rsa = 3; v.x_stall = 1; vt.push_back(v);
      v.name = "rt_unused"; v.use_rt = 0; v.use_rs = 1; v.x_stall = 0; vt.push_back(v);
      v = z; v.name = "no_load"; v.rwa = 5; v.use_rs = 1; v.rsa = 5; vt.push_back(v);
      v = z; v.name = "hilo_idle"; v.hilo = 1; vt.push_back(v);
      v = z; v.name = "mis_prio"; v.drce = 1; v.rwa = 5; v.use_rs = 1; v.rsa = 5;
      v.br = 1; v.tk = 1; v.ptk = 0; v.pbr = 1; v.pc = 32'h00400040; v.tgt = 32'h00400100;
      v.x_mis = 1; v.x_rpc = 32'h00400100; vt.push_back(v);
      v = z; v.name = "bad_tgt"; v.br = 1; v.tk = 1; v.pbr = 1; v.ptk = 1; v.pnpc = 32'h80;
      v.tgt = 32'h84; v.pc = 32'h00400050; v.x_mis = 1; v.x_rpc = 32'h84; vt.push_back(v);
      v = z; v.name = "ok_nt"; v.br = 1; v.pbr = 1; v.pc = 32'h00400060; v.tgt = 32'h00400200;
      v.x_rpc = 32'h00400064; vt.push_back(v);
      v = z; v.name = "ok_tk"; v.br = 1; v.tk = 1; v.pbr = 1; v.ptk = 1; v.pnpc = 32'h200;
      v.tgt = 32'h200; v.pc = 32'h00400070; v.x_rpc = 32'h200; vt.push_back(v);
      v = z; v.name = "nt_but_pred_tk"; v.br = 1; v.pbr = 1; v.ptk = 1; v.pnpc = 32'h300;
      v.tgt = 32'h300; v.pc = 32'h00400080; v.x_mis = 1; v.x_rpc = 32'h00400084; vt.push_back(v);
      v = z; v.name = "phantom_tk"; v.pbr = 1; v.ptk = 1; v.pnpc = 32'h400; v.x_mis = 1; vt.push_back(v);
      v = z; v.name = "phantom_nt"; v.pbr = 1; vt.push_back(v);
      vt.push_back(z);

      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.md_busy", {31'd0, md_busy}, 0);
      chk("rst.md_done", {31'd0, md_done}, 0);
      chk("rst.bp_upd_valid", {31'd0, bp_upd_valid}, 0);
      chk("rst.branch_cnt", branch_cnt, 0);
      chk("rst.mispred_cnt", mispred_cnt, 0);
      rst_n = 1'b1;

      m_bc = 0; m_mc = 0;
      foreach (vt[i]) begin
         @(posedge clk); #1;
         drive(vt[i]);
         @(negedge clk);
         check_cycle();
         m_bc = m_bc + {31'd0, vt[i].br};
         m_mc = m_mc + {31'd0, vt[i].x_mis};
      end

      // Mult/div interlock with id_hilo_use held throughout.
      @(posedge clk); #1;
      idle_inputs(); id_hilo_use = 1; exe_md_start = 1;
      @(negedge clk);
      chk("md.c0.busy", {31'd0, md_busy}, 0);
      chk("md.c0.stall", {31'd0, pc_stall}, 0);
      for (int c = 1; c <= MDC + 1; c++) begin
         @(posedge clk); #1;
         exe_md_start = 0;
         @(negedge clk);
         chk($sformatf("md.c%0d.busy", c), {31'd0, md_busy}, {31'd0, (c <= MDC)});
         chk($sformatf("md.c%0d.done", c), {31'd0, md_done}, {31'd0, (c == MDC)});
         chk($sformatf("md.c%0d.stall", c), {31'd0, idexe_stall}, {31'd0, (c <= MDC)});
      end

      // Async reset in the middle of a busy op.
      @(posedge clk); #1;
      idle_inputs(); exe_md_start = 1; exe_branch = 1;
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #2;
      chk("rstmid.pre_busy", {31'd0, md_busy}, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid.busy", {31'd0, md_busy}, 0);
      chk("rstmid.branch_cnt", branch_cnt, 0);
      chk("rstmid.mispred_cnt", mispred_cnt, 0);
      chk("rstmid.bp_valid", {31'd0, bp_upd_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < MDC + 3; c++) begin
         @(negedge clk);
         chk($sformatf("rstmid.after%0d", c), {30'd0, md_busy, md_done}, 0);
      end

      // Counter wrap from a forced all-ones value.
      @(negedge clk);
      force dut.branch_cnt_q = 32'hFFFFFFFF;
      #1 release dut.branch_cnt_q;
      chk("wrap.pre", branch_cnt, 32'hFFFFFFFF);
      @(posedge clk); #1;
      exe_branch = 1;
      @(posedge clk); #1;
      exe_branch = 0;
      @(negedge clk);
      chk("wrap.branch_cnt", branch_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
